// File: rtl/pipeline_ctrl_pkg.sv
// Purpose  : opcode classes, sequencer state encodings and stall-length type shared by the stall sequencer.
// Latency  : n/a (declarations and pure helper functions only).
// Backpress: n/a.
package pipeline_ctrl_pkg;

   localparam logic [3:0] OP_ATYPE = 4'b0001;
   localparam logic [3:0] OP_LW    = 4'b0110;
   localparam logic [3:0] OP_LB    = 4'b0100;
   localparam logic [3:0] OP_BEQ   = 4'b1100;
   localparam logic [3:0] OP_BLT   = 4'b1101;
   localparam logic [3:0] OP_BGT   = 4'b1110;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   // Number of bubble cycles a hazard needs (0 = no stall).
   typedef logic [1:0] stall_len_t;

   function automatic logic is_atype(input logic [3:0] op);
      return op == OP_ATYPE;
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LW) || (op == OP_LB);
   endfunction

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT);
   endfunction

endpackage

// File: rtl/pipeline_stall_sequencer_hazard_classifier.sv
// Purpose  : maps the ID/EX/MEM opcodes and hazard-detect flags to a stall length.
// Latency  : purely combinational, zero cycles.
// Backpress: none; evaluated every cycle, the sequencer decides whether the result is used.
// Ports    : id_op/ex_op/mem_op (4b opcodes), hazard (2b match flags) in; stall_len (2b) out.
module hazard_classifier
   import pipeline_ctrl_pkg::*;
(
   input  logic [3:0]  id_op,
   input  logic [3:0]  ex_op,
   input  logic [3:0]  mem_op,
   input  logic [1:0]  hazard,
   output stall_len_t  stall_len
);

   logic br_src_hit;
   logic alu_src_hit;

   assign br_src_hit  = hazard[1] & is_branch(id_op);
   assign alu_src_hit = hazard[0] & is_atype(id_op);

   // Ordered: a branch waiting on a load still in EX needs the longest wait,
   // so it must win over the shorter cases that could also match.
   always_comb begin
      stall_len = 2'd0;
      if (br_src_hit && is_load(ex_op)) begin
         stall_len = 2'd2;
      end else if (br_src_hit && is_atype(ex_op)) begin
         stall_len = 2'd1;
      end else if (br_src_hit && is_load(mem_op)) begin
         stall_len = 2'd1;
      end else if (alu_src_hit && is_load(ex_op)) begin
         stall_len = 2'd1;
      end
   end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Purpose  : sequences PC/IF-ID freezes, ID/EX bubbles and IF/ID flushes for the 5-stage pipe.
// Latency  : outputs are Mealy (same cycle as the hazard); multi-cycle stalls tracked in a small FSM.
// Backpress: mem_busy freezes everything; FSM state and remaining-stall count hold until it drops.
// Ports    : clk, rst_n; id_op/ex_op/mem_op, hazard, branch_taken, mem_busy in;
//            pc_we, ifid_we, idex_bubble, ifid_flush, pipe_freeze out.
// Config   : STALL_PERF_CNT_EN adds saturating stall_cycles / flush_count outputs (CNT_W bits).
module pipeline_stall_sequencer
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        id_op,
   input  logic [3:0]        ex_op,
   input  logic [3:0]        mem_op,
   input  logic [1:0]        hazard,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              pipe_freeze
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
`endif
);

   localparam int REM_W = $clog2(MAX_STALL) + 1;

   if (CNT_W < 1) begin : g_cnt_w_invalid
      $error("CNT_W must be at least 1");
   end

   state_t           state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   stall_len_t       stall_len;
   logic             branch_now;

   hazard_classifier u_classifier (
      .id_op     (id_op),
      .ex_op     (ex_op),
      .mem_op    (mem_op),
      .hazard    (hazard),
      .stall_len (stall_len)
   );

   assign branch_now = is_branch(id_op) & branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         ST_RUN: begin
            // A one-cycle stall stays in RUN: next cycle EX holds the bubble
            // and the classifier naturally sees the hazard gone.
            if (!mem_busy) begin
               if (stall_len > 2'd1) begin
                  state_d = ST_STALL;
                  rem_d   = REM_W'(stall_len) - REM_W'(1);
               end else if (stall_len == 2'd0 && branch_now) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_STALL: begin
            if (!mem_busy) begin
               if (rem_q <= REM_W'(1)) begin
                  state_d = ST_RUN;
                  rem_d   = '0;
               end else begin
                  rem_d   = rem_q - REM_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (!mem_busy) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            // Unused encoding: recover unconditionally, even while frozen.
            state_d = ST_RUN;
            rem_d   = '0;
         end
      endcase
   end

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      pipe_freeze = 1'b0;
      if (!rst_n) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         pipe_freeze = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               // Stall beats flush: the branch needs its operands before resolving.
               if (stall_len != 2'd0) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_bubble = 1'b1;
               end else if (branch_now) begin
                  ifid_flush  = 1'b1;
               end
            end
            ST_STALL: begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_bubble = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef STALL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else if (!mem_busy) begin
         if (idex_bubble && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (ifid_flush && flush_count != '1) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Purpose  : self-checking bench for pipeline_stall_sequencer (reference model plus directed literals).
// Latency  : n/a.
// Backpress: n/a.
module tb_pipeline_stall_sequencer;

   localparam int TB_CNT_W = 4;

   // {pc_we, ifid_we, idex_bubble, ifid_flush, pipe_freeze}
   localparam logic [4:0] NRM = 5'b11000;
   localparam logic [4:0] STL = 5'b00100;
   localparam logic [4:0] FLS = 5'b11010;
   localparam logic [4:0] FRZ = 5'b00001;
   localparam logic [4:0] RST = 5'b00100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] id_op, ex_op, mem_op;
   logic [1:0] hazard;
   logic       branch_taken, mem_busy;
   logic       pc_we, ifid_we, idex_bubble, ifid_flush, pipe_freeze;
`ifdef STALL_PERF_CNT_EN
   logic [TB_CNT_W-1:0] stall_cycles, flush_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipeline_stall_sequencer #(.CNT_W(TB_CNT_W), .MAX_STALL(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_op        (id_op),
      .ex_op        (ex_op),
      .mem_op       (mem_op),
      .hazard       (hazard),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .pc_we        (pc_we),
      .ifid_we      (ifid_we),
      .idex_bubble  (idex_bubble),
      .ifid_flush   (ifid_flush),
      .pipe_freeze  (pipe_freeze)
`ifdef STALL_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   wire [4:0] outs = {pc_we, ifid_we, idex_bubble, ifid_flush, pipe_freeze};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks "bubble cycles still owed" and "ID holds a flushed slot" rather than FSM states.
   function automatic int exp_len(input logic [3:0] i, input logic [3:0] e,
                                  input logic [3:0] m, input logic [1:0] h);
      bit br, ald, mld, aty_i, aty_e;
      br    = i inside {4'b1100, 4'b1101, 4'b1110};
      aty_i = (i == 4'b0001);
      aty_e = (e == 4'b0001);
      ald   = e inside {4'b0110, 4'b0100};
      mld   = m inside {4'b0110, 4'b0100};
      if (h[1] && br && ald)     return 2;
      if (h[1] && br && aty_e)   return 1;
      if (h[1] && br && mld)     return 1;
      if (h[0] && aty_i && ald)  return 1;
      return 0;
   endfunction

   int m_owed = 0, m_owed_n = 0;
   bit m_flushed = 1'b0, m_flushed_n = 1'b0;

   always @(negedge clk) begin
      logic [4:0] e;
      int         len;
      m_owed_n    = m_owed;
      m_flushed_n = m_flushed;
      if (!rst_n) begin
         e = RST;
         m_owed_n = 0;
         m_flushed_n = 1'b0;
      end else if (mem_busy) begin
         e = FRZ;
      end else if (m_owed > 0) begin
         e = STL;
         m_owed_n = m_owed - 1;
      end else if (m_flushed) begin
         e = NRM;
         m_flushed_n = 1'b0;
      end else begin
         len = exp_len(id_op, ex_op, mem_op, hazard);
         if (len > 0) begin
            e = STL;
            m_owed_n = len - 1;
         end else if ((id_op inside {4'b1100, 4'b1101, 4'b1110}) && branch_taken) begin
            e = FLS;
            m_flushed_n = 1'b1;
         end else begin
            e = NRM;
         end
      end
      chk("model_outs", {27'd0, outs}, {27'd0, e});
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owed    <= 0;
         m_flushed <= 1'b0;
      end else begin
         m_owed    <= m_owed_n;
         m_flushed <= m_flushed_n;
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Apply one cycle of inputs and check the hand-computed output vector.
   task automatic cyc(input string tag, input logic [3:0] i, input logic [3:0] e,
                      input logic [3:0] m, input logic [1:0] h, input logic bt,
                      input logic mb, input logic [4:0] exp);
      id_op = i; ex_op = e; mem_op = m; hazard = h; branch_taken = bt; mem_busy = mb;
      @(negedge clk);
      chk(tag, {27'd0, outs}, {27'd0, exp});
      nxt();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      id_op = '0; ex_op = '0; mem_op = '0; hazard = '0; branch_taken = 1'b0; mem_busy = 1'b0;
      @(negedge clk);
      chk("reset_outs", {27'd0, outs}, {27'd0, RST});
      nxt();
      rst_n = 1'b1;

      // 1: A-type after load -> single bubble
      cyc("s1_stall",   4'b0001, 4'b0110, 4'b0000, 2'b01, 1'b0, 1'b0, STL);
      cyc("s1_run",     4'b0001, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      // 2: branch after load in EX -> two bubbles, second ignores inputs
      cyc("s2_stall1",  4'b1100, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0, STL);
      cyc("s2_stall2",  4'b1100, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0, STL);
      cyc("s2_run",     4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      // 3: taken branch after load in MEM -> stall, then flush, FLUSH cycle ignores hazard
      cyc("s3_stall",   4'b1101, 4'b0000, 4'b0110, 2'b10, 1'b1, 1'b0, STL);
      cyc("s3_flush",   4'b1101, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, FLS);
      cyc("s3_flushst", 4'b1101, 4'b0110, 4'b0000, 2'b10, 1'b1, 1'b0, NRM);
      cyc("s3_run",     4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
`ifdef STALL_PERF_CNT_EN
      chk("perf_stalls", 32'(stall_cycles), 32'd4);
      chk("perf_flush",  32'(flush_count),  32'd1);
`endif
      // 4: freeze in the middle of a two-cycle stall; one bubble still owed afterwards
      cyc("s4_stall1",  4'b1100, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0, STL);
      for (int k = 0; k < 3; k++)
         cyc("s4_freeze", 4'b1100, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b1, FRZ);
      cyc("s4_resume",  4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, STL);
      cyc("s4_run",     4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);

      // further classifier patterns and priorities
      cyc("lb_atype",   4'b0001, 4'b0100, 4'b0000, 2'b01, 1'b0, 1'b0, STL);
      cyc("lb_run",     4'b0001, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      cyc("wrong_bit",  4'b0001, 4'b0110, 4'b0000, 2'b10, 1'b0, 1'b0, NRM);
      cyc("bgt_atype",  4'b1110, 4'b0001, 4'b0000, 2'b10, 1'b1, 1'b0, STL);
      cyc("bgt_flush",  4'b1110, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, FLS);
      cyc("bgt_after",  4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      cyc("br_h0_fl",   4'b1100, 4'b0110, 4'b0000, 2'b01, 1'b1, 1'b0, FLS);
      cyc("br_h0_nxt",  4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      cyc("br_untaken", 4'b1100, 4'b0110, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      cyc("busy_taken", 4'b1101, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, FRZ);
      cyc("late_flush", 4'b1101, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, FLS);
      cyc("late_nrm",   4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      cyc("prio_2a",    4'b1100, 4'b0110, 4'b0110, 2'b11, 1'b1, 1'b0, STL);
      cyc("prio_2b",    4'b1100, 4'b0110, 4'b0110, 2'b11, 1'b1, 1'b0, STL);
      cyc("prio_fl",    4'b1100, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, FLS);
      cyc("prio_nrm",   4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);

      // 5: reset asserted asynchronously while in STALL (frozen, so outputs differ from reset)
      cyc("s5_stall1",  4'b1100, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0, STL);
      id_op = '0; ex_op = '0; hazard = '0; mem_busy = 1'b1;
      #1;
      chk("s5_busy", {27'd0, outs}, {27'd0, FRZ});
      rst_n = 1'b0;
      #1;
      chk("s5_async_rst", {27'd0, outs}, {27'd0, RST});
      nxt();
      nxt();
      mem_busy = 1'b0;
      rst_n = 1'b1;
      cyc("s5_no_resid", 4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);

`ifdef STALL_PERF_CNT_EN
      chk("perf_rst_clr", 32'(stall_cycles), 32'd0);
      for (int k = 0; k < 10; k++) begin
         cyc("sat_a", 4'b1100, 4'b0110, 4'b0000, 2'b10, 1'b0, 1'b0, STL);
         cyc("sat_b", 4'b1100, 4'b0110, 4'b0000, 2'b10, 1'b0, 1'b0, STL);
      end
      cyc("sat_nrm", 4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, NRM);
      chk("perf_sat", 32'(stall_cycles), 32'hF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
